// File: rtl/bullet_pool.sv
// Per-player bullet pool: spawns on fire, steps every STEP_DIV cycles, retires on wall or enemy overlap.
// Slots update one edge after the event; hit/fire_dropped/bullet_state/active_count are registered, no backpressure.
module bullet_pool #(
    parameter int NUM_BULLETS  = 4,
    parameter int SPEED        = 8,
    parameter int STEP_DIV     = 4,
    parameter int PLAYER_INDEX = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         game_over,
    input  logic         bullet_fire,
    input  logic [1:0]   bullet_direction,
    input  logic [9:0]   tank_x,
    input  logic [9:0]   tank_y,
    input  logic [9:0]   enemy_x,
    input  logic [9:0]   enemy_y,
    input  logic         enemy_active,
    input  logic [255:0] wall_map,
    input  logic [2:0]   state_idx,
    output logic [31:0]  bullet_state,
    output logic         hit,
    output logic         fire_dropped,
    output logic [3:0]   active_count
);
    localparam int          CW      = $clog2(STEP_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(STEP_DIV - 1);
    localparam logic [10:0] SPD     = 11'(SPEED);
    localparam logic [1:0]  PI2     = 2'(PLAYER_INDEX);

    logic [CW-1:0]                step_cnt_q, step_cnt_d;
    logic [NUM_BULLETS-1:0]       act_q, act_d;
    logic [NUM_BULLETS-1:0][9:0]  x_q, x_d, y_q, y_d;
    logic [NUM_BULLETS-1:0][1:0]  dir_q, dir_d;
    logic [31:0]                  bs_q, bs_d;
    logic                         hit_q, hit_d;
    logic                         drop_q, drop_d;
    logic [3:0]                   cnt_q, cnt_d;

    logic        tick, spawn, free_found;
    logic [2:0]  free_idx;
    logic [10:0] nx, ny, cx, cy, ex, ey;
    logic        off_map, wall, overlap;

    assign tick  = (step_cnt_q == CNT_MAX) && !game_over;
    assign spawn = bullet_fire && !game_over;
    assign ex    = {1'b0, enemy_x};
    assign ey    = {1'b0, enemy_y};

    always_comb begin
        step_cnt_d = step_cnt_q;
        if (!game_over) begin
            step_cnt_d = (step_cnt_q == CNT_MAX) ? '0 : step_cnt_q + CW'(1);
        end
    end

    // Lowest-index free slot, judged on pre-tick occupancy.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = NUM_BULLETS - 1; i >= 0; i--) begin
            if (!act_q[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
    end

    always_comb begin
        act_d   = act_q;
        x_d     = x_q;
        y_d     = y_q;
        dir_d   = dir_q;
        hit_d   = 1'b0;
        drop_d  = spawn && !free_found;
        nx      = '0;
        ny      = '0;
        cx      = '0;
        cy      = '0;
        off_map = 1'b0;
        wall    = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            nx = {1'b0, x_q[i]};
            ny = {1'b0, y_q[i]};
            case (dir_q[i])
                2'b00:   ny = ny - SPD;
                2'b01:   ny = ny + SPD;
                2'b10:   nx = nx - SPD;
                default: nx = nx + SPD;
            endcase
            cx = (nx + 11'd4) >> 5;
            cy = (ny + 11'd4) >> 5;
            // Underflow wraps above 511; a centre falling past cell 15 is off the map too.
            off_map = (nx > 11'd511) || (ny > 11'd511) || (cx[10:4] != '0) || (cy[10:4] != '0);
            wall    = off_map || wall_map[{cx[3:0], cy[3:0]}];
            overlap = enemy_active && (nx < ex + 11'd32) && (nx + 11'd8 > ex)
                                   && (ny < ey + 11'd32) && (ny + 11'd8 > ey);
            if (tick && act_q[i]) begin
                if (wall) begin
                    act_d[i] = 1'b0;
                end else if (overlap) begin
                    act_d[i] = 1'b0;
                    hit_d    = 1'b1;
                end else begin
                    x_d[i] = nx[9:0];
                    y_d[i] = ny[9:0];
                end
            end
            if (spawn && free_found && (free_idx == 3'(i))) begin
                act_d[i] = 1'b1;
                x_d[i]   = tank_x + 10'd12;
                y_d[i]   = tank_y + 10'd12;
                dir_d[i] = bullet_direction;
            end
        end
    end

    always_comb begin
        bs_d  = '0;
        cnt_d = '0;
        for (int i = 0; i < NUM_BULLETS; i++) begin
            if (state_idx == 3'(i)) begin
                bs_d = {1'b1, PI2, act_q[i], x_q[i], y_q[i], dir_q[i], 3'b001, 1'b0, dir_q[i]};
            end
            cnt_d = cnt_d + {3'b000, act_d[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_q <= '0;
            act_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            dir_q      <= '0;
            bs_q       <= '0;
            hit_q      <= 1'b0;
            drop_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            step_cnt_q <= step_cnt_d;
            act_q      <= act_d;
            x_q        <= x_d;
            y_q        <= y_d;
            dir_q      <= dir_d;
            bs_q       <= bs_d;
            hit_q      <= hit_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bullet_state = bs_q;
    assign hit          = hit_q;
    assign fire_dropped = drop_q;
    assign active_count = cnt_q;

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool with a cycle-level reference model and hand-computed checkpoints.
module tb_bullet_pool;
    localparam int NB = 4, SPD = 8, SD = 4, PI = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         game_over = 1'b0, bullet_fire = 1'b0, enemy_active = 1'b0;
    logic [1:0]   bullet_direction = 2'd0;
    logic [9:0]   tank_x = '0, tank_y = '0, enemy_x = '0, enemy_y = '0;
    logic [255:0] wall_map = '0;
    logic [2:0]   state_idx = '0;
    logic [31:0]  bullet_state;
    logic         hit, fire_dropped;
    logic [3:0]   active_count;

    int vectors = 0, errors = 0;

    always #5 clk = ~clk;

    bullet_pool #(.NUM_BULLETS(NB), .SPEED(SPD), .STEP_DIV(SD), .PLAYER_INDEX(PI)) dut (
        .clk(clk), .reset(reset), .game_over(game_over), .bullet_fire(bullet_fire),
        .bullet_direction(bullet_direction), .tank_x(tank_x), .tank_y(tank_y),
        .enemy_x(enemy_x), .enemy_y(enemy_y), .enemy_active(enemy_active),
        .wall_map(wall_map), .state_idx(state_idx), .bullet_state(bullet_state),
        .hit(hit), .fire_dropped(fire_dropped), .active_count(active_count)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input int a, input int x, input int y, input int d);
        return {1'b1, 2'(PI), 1'(a), 10'(x), 10'(y), 2'(d), 3'b001, 1'b0, 2'(d)};
    endfunction

    function automatic logic [255:0] border_map();
        logic [255:0] m;
        m = '0;
        for (int cx = 0; cx < 16; cx++)
            for (int cy = 0; cy < 16; cy++)
                if (cx == 0 || cx == 15 || cy == 0 || cy == 15) m[cx*16+cy] = 1'b1;
        return m;
    endfunction

    // Reference model: pool as plain integer arrays, updated once per clock.
    int m_act[NB], m_x[NB], m_y[NB], m_dir[NB];
    int m_cnt = 0, m_count = 0;
    bit m_hit = 0, m_drop = 0;
    logic [31:0] m_bs = '0;

    always @(posedge clk or posedge reset) begin : model
        int old_act[NB];
        bit tk;
        int nx, ny, cx, cy, fi, si;
        if (reset) begin
            for (int i = 0; i < NB; i++) begin
                m_act[i] = 0; m_x[i] = 0; m_y[i] = 0; m_dir[i] = 0;
            end
            m_cnt = 0; m_count = 0; m_hit = 0; m_drop = 0; m_bs = '0;
        end else begin
            old_act = m_act;
            tk = (m_cnt == SD - 1) && !game_over;
            si = int'(state_idx);
            m_bs = (si < NB) ? word(m_act[si], m_x[si], m_y[si], m_dir[si]) : 32'd0;
            m_hit = 0;
            m_drop = 0;
            if (tk) begin
                for (int i = 0; i < NB; i++) begin
                    if (old_act[i] != 0) begin
                        nx = m_x[i]; ny = m_y[i];
                        case (m_dir[i])
                            0: ny = ny - SPD;
                            1: ny = ny + SPD;
                            2: nx = nx - SPD;
                            default: nx = nx + SPD;
                        endcase
                        cx = (nx + 4) / 32;
                        cy = (ny + 4) / 32;
                        if (nx < 0 || nx > 511 || ny < 0 || ny > 511 || cx > 15 || cy > 15)
                            m_act[i] = 0;
                        else if (wall_map[cx*16+cy])
                            m_act[i] = 0;
                        else if (enemy_active && nx < int'(enemy_x) + 32 && nx + 8 > int'(enemy_x)
                                 && ny < int'(enemy_y) + 32 && ny + 8 > int'(enemy_y)) begin
                            m_act[i] = 0;
                            m_hit = 1;
                        end else begin
                            m_x[i] = nx; m_y[i] = ny;
                        end
                    end
                end
            end
            if (bullet_fire && !game_over) begin
                fi = -1;
                for (int i = NB - 1; i >= 0; i--) if (old_act[i] == 0) fi = i;
                if (fi < 0) m_drop = 1;
                else begin
                    m_act[fi] = 1;
                    m_x[fi] = (int'(tank_x) + 12) % 1024;
                    m_y[fi] = (int'(tank_y) + 12) % 1024;
                    m_dir[fi] = int'(bullet_direction);
                end
            end
            if (!game_over) m_cnt = (m_cnt + 1) % SD;
            m_count = 0;
            for (int i = 0; i < NB; i++) m_count += m_act[i];
        end
    end

    always @(negedge clk) begin
        chk("model_bullet_state", bullet_state, m_bs);
        chk("model_hit", {31'd0, hit}, {31'd0, m_hit});
        chk("model_fire_dropped", {31'd0, fire_dropped}, {31'd0, m_drop});
        chk("model_active_count", {28'd0, active_count}, 32'(m_count));
    end

    task automatic nxt(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Asserts reset mid low-phase, releases it at a negedge; the next posedge is E1.
    task automatic restart();
        @(negedge clk);
        #2 reset = 1'b1;
        nxt(2);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        wall_map = border_map();
        nxt(2);
        chk("reset_bullet_state", bullet_state, 32'd0);
        chk("reset_active_count", {28'd0, active_count}, 32'd0);
        chk("reset_hit", {31'd0, hit}, 32'd0);
        chk("reset_fire_dropped", {31'd0, fire_dropped}, 32'd0);

        // Spawn, three steps right, then wall retirement at x'=476.
        tank_x = 10'd32; tank_y = 10'd32; bullet_direction = 2'd3; state_idx = 3'd0;
        reset = 1'b0; bullet_fire = 1'b1;
        nxt(1); bullet_fire = 1'b0;
        nxt(1);
        chk("spawn_word", bullet_state, {1'b1, 2'd2, 1'b1, 10'd44, 10'd44, 2'd3, 3'b001, 3'b011});
        nxt(11);
        chk("three_ticks_word", bullet_state, {1'b1, 2'd2, 1'b1, 10'd68, 10'd44, 2'd3, 3'b001, 3'b011});
        chk("three_ticks_count", {28'd0, active_count}, 32'd1);
        nxt(202);
        chk("pre_wall_count", {28'd0, active_count}, 32'd1);
        nxt(1);
        chk("wall_retire_count", {28'd0, active_count}, 32'd0);
        chk("wall_retire_nohit", {31'd0, hit}, 32'd0);
        nxt(1);
        chk("wall_retire_word", bullet_state, {1'b1, 2'd2, 1'b0, 10'd468, 10'd44, 2'd3, 3'b001, 3'b011});

        // Enemy hit at x'=92, not at 84.
        enemy_x = 10'd96; enemy_y = 10'd32; enemy_active = 1'b1;
        restart(); bullet_fire = 1'b1;
        nxt(1); bullet_fire = 1'b0;
        nxt(22);
        chk("prehit_hit", {31'd0, hit}, 32'd0);
        nxt(1);
        chk("hit_pulse", {31'd0, hit}, 32'd1);
        chk("hit_frees_slot", {28'd0, active_count}, 32'd0);
        nxt(1);
        chk("hit_one_cycle", {31'd0, hit}, 32'd0);

        // Same flight with the enemy dead: bullet passes through.
        enemy_active = 1'b0;
        restart(); bullet_fire = 1'b1;
        nxt(1); bullet_fire = 1'b0;
        nxt(24);
        chk("no_hit_inactive_count", {28'd0, active_count}, 32'd1);
        chk("no_hit_inactive_word", bullet_state, {1'b1, 2'd2, 1'b1, 10'd92, 10'd44, 2'd3, 3'b001, 3'b011});

        // Pool full: five pulses, fifth dropped; slot 1 (upward) dies on the top wall and is reused.
        restart();
        for (int k = 0; k < 5; k++) begin
            bullet_direction = (k == 1) ? 2'd0 : 2'd3;
            bullet_fire = 1'b1;
            nxt(1); bullet_fire = 1'b0;
            if (k == 4) begin
                chk("pool_full_drop", {31'd0, fire_dropped}, 32'd1);
                chk("pool_full_count", {28'd0, active_count}, 32'd4);
            end else nxt(1);
        end
        nxt(1);
        chk("drop_one_cycle", {31'd0, fire_dropped}, 32'd0);
        nxt(2);
        chk("slot1_wall_count", {28'd0, active_count}, 32'd3);
        tank_x = 10'd64; tank_y = 10'd64; bullet_direction = 2'd1; state_idx = 3'd1;
        bullet_fire = 1'b1;
        nxt(1); bullet_fire = 1'b0;
        nxt(1);
        chk("slot1_reuse_word", bullet_state, {1'b1, 2'd2, 1'b1, 10'd76, 10'd76, 2'd1, 3'b001, 3'b001});
        chk("slot1_reuse_count", {28'd0, active_count}, 32'd4);

        // Freeze for 20 edges, then divider resumes from its held phase.
        tank_x = 10'd32; tank_y = 10'd32; bullet_direction = 2'd3; state_idx = 3'd0;
        restart(); bullet_fire = 1'b1;
        nxt(1); bullet_fire = 1'b0;
        nxt(12);
        game_over = 1'b1;
        for (int k = 0; k < 20; k++) begin
            bullet_fire = (k == 5);
            nxt(1);
        end
        bullet_fire = 1'b0;
        chk("freeze_word", bullet_state, {1'b1, 2'd2, 1'b1, 10'd68, 10'd44, 2'd3, 3'b001, 3'b011});
        chk("freeze_fire_ignored", {28'd0, active_count}, 32'd1);
        game_over = 1'b0;
        nxt(3);
        chk("resume_before_tick", bullet_state, {1'b1, 2'd2, 1'b1, 10'd68, 10'd44, 2'd3, 3'b001, 3'b011});
        nxt(1);
        chk("resume_after_tick", bullet_state, {1'b1, 2'd2, 1'b1, 10'd76, 10'd44, 2'd3, 3'b001, 3'b011});
        state_idx = 3'd5;
        nxt(1);
        chk("idx_out_of_range", bullet_state, 32'd0);
        state_idx = 3'd0;

        // Asynchronous reset between edges with three bullets live.
        restart();
        for (int k = 0; k < 3; k++) begin
            bullet_fire = 1'b1;
            nxt(1); bullet_fire = 1'b0;
            nxt(1);
        end
        chk("pre_async_count", {28'd0, active_count}, 32'd3);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_bullet_state", bullet_state, 32'd0);
        chk("async_active_count", {28'd0, active_count}, 32'd0);
        chk("async_hit", {31'd0, hit}, 32'd0);
        chk("async_fire_dropped", {31'd0, fire_dropped}, 32'd0);
        nxt(2);
        reset = 1'b0;
        nxt(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/bullet_pool.md
# bullet_pool

Per-player bullet engine sitting directly downstream of the tank controller. It consumes the tank's one-cycle `bullet_fire` pulse, `bullet_direction`, and the tank position. It maintains a small pool of in-flight bullets, advances them on a fixed step tick, and retires them on wall or enemy-tank collision. It reports hits to the opposing tank's `killed` input and serves 32-bit OAM state words for the renderer.

## Interface
Parameters:
- `NUM_BULLETS`, default 4: pool size (1–8).
- `SPEED`, default 8: pixels moved per step.
- `STEP_DIV`, default 4: clock cycles per movement step (≥2).
- `PLAYER_INDEX`, default 0: owner ID, packed into state words.

Ports:
- `clk`  in  1  single system clock; one clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `game_over`  in  1  freeze: no spawn, no movement, divider holds.
- `bullet_fire`  in  1  spawn request from the tank, one-cycle pulse.
- `bullet_direction`  in  2  00 up, 01 down, 10 left, 11 right.
- `tank_x`, `tank_y`  in  10 each  owning tank's top-left pixel.
- `enemy_x`, `enemy_y`  in  10 each  enemy tank's top-left pixel.
- `enemy_active`  in  1  enemy alive; hits are only counted when 1.
- `wall_map`  in  256  shared 16×16 wall map, 32-px cells; bit `cx*16+cy` = 1 means wall.
- `state_idx`  in  3  slot selected for readout.
- `bullet_state`  out  32  registered state word of the selected slot.
- `hit`  out  1  one-cycle pulse; feeds the enemy's `killed`.
- `fire_dropped`  out  1  one-cycle pulse; spawn refused because the pool is full.
- `active_count`  out  4  number of live slots.

## Operation
- Each slot holds: `active`, `x[9:0]`, `y[9:0]`, `dir[1:0]`. Bullets are 8×8 px.
- **Step divider:** `step_cnt` counts 0..STEP_DIV-1 and wraps. `tick` = (`step_cnt` == STEP_DIV-1) && !`game_over`. The counter holds while `game_over`=1.
- **Spawn:** on `bullet_fire`=1 && !`game_over`, claim the lowest-index inactive slot.
  - Set x = `tank_x`+12, y = `tank_y`+12, dir = `bullet_direction`, active = 1.
  - If no slot is free, pulse `fire_dropped` and leave the pool unchanged.
- **Move (on tick, all active slots in parallel):**
  - Compute the candidate position: up y−SPEED, down y+SPEED, left x−SPEED, right x+SPEED, using 11-bit arithmetic.
  - Wall check: centre cell cx = (x'+4)>>5, cy = (y'+4)>>5. Retire the slot if the candidate underflows (bit 10 set), exceeds 511, or `wall_map[cx*16+cy]`=1. A wall retirement never produces a hit.
  - Hit check (only if not retired by a wall): overlap when x' < enemy_x+32, x'+8 > enemy_x, y' < enemy_y+32, and y'+8 > enemy_y, all 11-bit, with `enemy_active`=1. On overlap, retire the slot and assert `hit`.
  - Otherwise commit x', y'.
- Multiple slots hitting on the same tick produce one `hit` pulse.
- Spawn coincident with tick: the new slot is loaded at spawn position and is not moved on that tick. Other slots move normally.
- State word: {1'b1, PLAYER_INDEX[1:0], active, x, y, dir, rom_row=3'b001, rom_col={1'b0,dir}}.
  - Inactive slots report active=0 with their last coordinates.
  - `state_idx` ≥ NUM_BULLETS reads all-zero.
- `active_count` is the registered popcount of the active bits.

## Timing
- Reset (asynchronous): all slots inactive, x = y = dir = 0, `step_cnt`=0, `bullet_state`=0, `hit`=0, `fire_dropped`=0, `active_count`=0.
- Spawn latency: slot active and readable from the edge after the `bullet_fire` sample. `bullet_state` shows it one cycle later (registered read).
- `hit` and `fire_dropped` are registered; each is high for exactly one cycle after the edge that processed the event.
- First move occurs on the first tick after spawn. Step period is STEP_DIV cycles.
- `game_over` mid-flight: positions freeze and `hit` is not generated. On deassert, the divider resumes from its held value.
- Reset mid-flight clears everything immediately, without waiting for a clock edge.

## Test plan
- **Spawn and move:** reset, empty map except border walls, STEP_DIV=4, SPEED=8. Tank at (32,32), fire with dir=11 → slot0 = (44,44), active. After 3 ticks x=68, y=44; `active_count`=1.
- **Wall retirement:** continue the previous scenario. On the tick where x' reaches 476 (cell 15), the slot goes inactive, `hit` stays 0, and `active_count` returns to 0.
- **Hit:** enemy at (96,32) active, bullet dir=11 from (44,44). On the tick producing x'=68 (68+8>96 false), no hit. At x'=92, overlap → one `hit` pulse and the slot is freed. Repeat with `enemy_active`=0 → no hit; the bullet continues.
- **Pool full:** NUM_BULLETS=4, five fire pulses spaced 1 cycle apart → slots 0–3 active, fifth yields one `fire_dropped` pulse. Free slot 1 via a wall, fire again → slot 1 is reused.
- **Freeze and readout:** assert `game_over` for 20 cycles → positions and `step_cnt` unchanged, fire ignored. `state_idx`=5 with NUM_BULLETS=4 → `bullet_state`=0.
- **Async reset mid-flight:** assert `reset` between clock edges while 3 bullets are active → all outputs 0 before the next edge.
